// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the generic UART receiver.
// Holds the frame FSM states, synchroniser depth and parity helper.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2,
      S_BREAK_WAIT
   } rx_state_e;

   localparam int SYNC_STAGES  = 2;
   localparam int MIN_DATA_LEN = 5;

   // Expected parity bit over the low len bits; typ=1 selects odd.
   function automatic logic calc_parity(
      input logic [31:0] data,
      input int          len,
      input logic        typ
   );
      logic p;
      p = typ;
      for (int i = 0; i < 32; i++) begin
         if (i < len) p = p ^ data[i];
      end
      return p;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, per-bit oversampling counter and 3-sample vote.
// Strobes bit_done at the decision point and bit_end on the last tick.
module uart_rx_sampler #(
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rx_in,
   input  logic                      en,
   input  logic                      clr,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic                      rx_s,
   output logic                      bit_done,
   output logic                      bit_end,
   output logic                      bit_val
);
   import uart_rx_pkg::*;

   logic [SYNC_STAGES-1:0]    sync_q;
   logic [PRESCALE_WIDTH-1:0] edge_cnt;
   logic [PRESCALE_WIDTH-1:0] half;
   logic [PRESCALE_WIDTH-1:0] half_m1;
   logic [PRESCALE_WIDTH-1:0] half_p1;
   logic [PRESCALE_WIDTH-1:0] last;
   logic                      s0;
   logic                      s1;

   assign half    = prescale >> 1;
   assign half_m1 = half - PRESCALE_WIDTH'(1);
   assign half_p1 = half + PRESCALE_WIDTH'(1);
   assign last    = prescale - PRESCALE_WIDTH'(1);

   assign rx_s     = sync_q[SYNC_STAGES-1];
   assign bit_done = en && (edge_cnt == half_p1);
   assign bit_end  = en && (edge_cnt == last);
   assign bit_val  = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '1;
         edge_cnt <= '0;
         s0       <= 1'b1;
         s1       <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
         if (clr || !en || bit_end) begin
            edge_cnt <= '0;
         end else begin
            edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
         end
         if (en && edge_cnt == half_m1) s0 <= rx_s;
         if (en && edge_cnt == half)    s1 <= rx_s;
      end
   end

endmodule

// File: rtl/uart_rx_gen.sv
// Runtime-configurable UART receiver with parity, 1/2 stop bits,
// break detection and a valid/ready holding register.
module uart_rx_gen #(
   parameter int DATA_WIDTH_MAX = 9,
   parameter int PRESCALE_WIDTH = 6,
   parameter int LEN_WIDTH      = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      RX_IN,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   input  logic                      STOP2,
   input  logic [LEN_WIDTH-1:0]      Data_Len,
   input  logic [PRESCALE_WIDTH-1:0] Prescale,
   input  logic                      Data_Ready,
   output logic [DATA_WIDTH_MAX-1:0] P_DATA,
   output logic                      data_valid,
   output logic                      Parity_Error,
   output logic                      Stop_Error,
   output logic                      Overrun_Error,
   output logic                      Break_Det
);
   import uart_rx_pkg::*;

   rx_state_e                 state;
   logic                      par_en_q;
   logic                      par_typ_q;
   logic                      stop2_q;
   logic [LEN_WIDTH-1:0]      len_q;
   logic [PRESCALE_WIDTH-1:0] ps_q;
   logic [DATA_WIDTH_MAX-1:0] shift_q;
   logic [LEN_WIDTH-1:0]      bit_cnt;
   logic                      all_zero;
   logic                      par_bad;
   logic                      stop_bad;

   logic [LEN_WIDTH-1:0]      len_eff;
   logic [PRESCALE_WIDTH-1:0] ps_cur;
   logic                      rx_s;
   logic                      bit_done;
   logic                      bit_end;
   logic                      bit_val;
   logic                      counting;
   logic                      start_det;
   logic                      last_stop;
   logic                      frame_end;
   logic                      glitch;
   logic                      stop_fail;
   logic                      is_break;
   logic                      good;

   always_comb begin
      len_eff = Data_Len;
      if (Data_Len < LEN_WIDTH'(MIN_DATA_LEN)) begin
         len_eff = LEN_WIDTH'(MIN_DATA_LEN);
      end else if (Data_Len > LEN_WIDTH'(DATA_WIDTH_MAX)) begin
         len_eff = LEN_WIDTH'(DATA_WIDTH_MAX);
      end
   end

   assign counting  = (state == S_START)  || (state == S_DATA)  ||
                      (state == S_PARITY) || (state == S_STOP1) ||
                      (state == S_STOP2);
   assign start_det = (state == S_IDLE) && !rx_s;
   assign ps_cur    = (state == S_IDLE) ? Prescale : ps_q;

   // The frame closes mid-way through its final stop bit.
   assign last_stop = ((state == S_STOP1) && !stop2_q) ||
                      (state == S_STOP2);
   assign frame_end = bit_done && last_stop;
   assign glitch    = bit_done && (state == S_START) && bit_val;

   assign stop_fail = stop_bad | ~bit_val;
   assign is_break  = all_zero & ~bit_val;
   assign good      = !stop_fail && !(par_en_q && par_bad);

   uart_rx_sampler #(
      .PRESCALE_WIDTH(PRESCALE_WIDTH)
   ) u_sampler (
      .clk      (CLK),
      .rst      (RST),
      .rx_in    (RX_IN),
      .en       (start_det || counting),
      .clr      (frame_end || glitch),
      .prescale (ps_cur),
      .rx_s     (rx_s),
      .bit_done (bit_done),
      .bit_end  (bit_end),
      .bit_val  (bit_val)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= S_IDLE;
         par_en_q      <= 1'b0;
         par_typ_q     <= 1'b0;
         stop2_q       <= 1'b0;
         len_q         <= '0;
         ps_q          <= '0;
         shift_q       <= '0;
         bit_cnt       <= '0;
         all_zero      <= 1'b0;
         par_bad       <= 1'b0;
         stop_bad      <= 1'b0;
         P_DATA        <= '0;
         data_valid    <= 1'b0;
         Parity_Error  <= 1'b0;
         Stop_Error    <= 1'b0;
         Overrun_Error <= 1'b0;
         Break_Det     <= 1'b0;
      end else begin
         Parity_Error  <= 1'b0;
         Stop_Error    <= 1'b0;
         Overrun_Error <= 1'b0;
         Break_Det     <= 1'b0;
         if (data_valid && Data_Ready) data_valid <= 1'b0;

         unique case (state)
            S_IDLE: begin
               if (!rx_s) begin
                  par_en_q  <= PAR_EN;
                  par_typ_q <= PAR_TYP;
                  stop2_q   <= STOP2;
                  len_q     <= len_eff;
                  ps_q      <= Prescale;
                  shift_q   <= '0;
                  bit_cnt   <= '0;
                  all_zero  <= 1'b1;
                  par_bad   <= 1'b0;
                  stop_bad  <= 1'b0;
                  state     <= S_START;
               end
            end
            S_START: begin
               if (glitch) begin
                  state <= S_IDLE;
               end else if (bit_end) begin
                  state <= S_DATA;
               end
            end
            S_DATA: begin
               if (bit_done) begin
                  shift_q[bit_cnt] <= bit_val;
                  if (bit_val) all_zero <= 1'b0;
               end
               if (bit_end) begin
                  if (bit_cnt == len_q - LEN_WIDTH'(1)) begin
                     state <= par_en_q ? S_PARITY : S_STOP1;
                  end else begin
                     bit_cnt <= bit_cnt + LEN_WIDTH'(1);
                  end
               end
            end
            S_PARITY: begin
               if (bit_done) begin
                  par_bad <= bit_val != calc_parity(32'(shift_q),
                                                    int'(len_q),
                                                    par_typ_q);
                  if (bit_val) all_zero <= 1'b0;
               end
               if (bit_end) state <= S_STOP1;
            end
            S_STOP1: begin
               if (stop2_q) begin
                  if (bit_done) begin
                     stop_bad <= ~bit_val;
                     if (bit_val) all_zero <= 1'b0;
                  end
                  if (bit_end) state <= S_STOP2;
               end
            end
            S_STOP2: begin
            end
            S_BREAK_WAIT: begin
               if (rx_s) state <= S_IDLE;
            end
         endcase

         if (frame_end) begin
            if (is_break) begin
               Break_Det <= 1'b1;
               state     <= S_BREAK_WAIT;
            end else begin
               state        <= S_IDLE;
               Parity_Error <= par_en_q & par_bad;
               Stop_Error   <= stop_fail;
               if (good) begin
                  if (!data_valid || Data_Ready) begin
                     P_DATA     <= shift_q;
                     data_valid <= 1'b1;
                  end else begin
                     Overrun_Error <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_gen.sv
// Directed and randomized frames checked against a frame-level model
// of the receiver's result outputs and holding register.
module tb_uart_rx_gen;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       RX_IN = 1'b1;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic       STOP2 = 1'b0;
   logic [3:0] Data_Len = 4'd8;
   logic [5:0] Prescale = 6'd8;
   logic       Data_Ready = 1'b1;
   logic [8:0] P_DATA;
   logic       data_valid;
   logic       Parity_Error;
   logic       Stop_Error;
   logic       Overrun_Error;
   logic       Break_Det;

   uart_rx_gen dut (
      .CLK           (CLK),
      .RST           (RST),
      .RX_IN         (RX_IN),
      .PAR_EN        (PAR_EN),
      .PAR_TYP       (PAR_TYP),
      .STOP2         (STOP2),
      .Data_Len      (Data_Len),
      .Prescale      (Prescale),
      .Data_Ready    (Data_Ready),
      .P_DATA        (P_DATA),
      .data_valid    (data_valid),
      .Parity_Error  (Parity_Error),
      .Stop_Error    (Stop_Error),
      .Overrun_Error (Overrun_Error),
      .Break_Det     (Break_Det)
   );

   always #5 CLK = ~CLK;

   int n_assert = 0;
   int n_fail   = 0;

   int         n_perr = 0;
   int         n_serr = 0;
   int         n_ovr  = 0;
   int         n_brk  = 0;
   int         n_load = 0;
   int         n_vcyc = 0;
   int         n_unstable = 0;
   logic       dv_prev = 1'b0;
   logic [8:0] pd_prev = '0;
   logic [8:0] last_load = '0;

   // Holding-register model: occupancy and contents.
   bit         hv = 1'b0;
   logic [8:0] hd = '0;

   always @(negedge CLK) begin
      if (Parity_Error)  n_perr++;
      if (Stop_Error)    n_serr++;
      if (Overrun_Error) n_ovr++;
      if (Break_Det)     n_brk++;
      if (data_valid)    n_vcyc++;
      if (data_valid && !dv_prev) begin
         n_load++;
         last_load = P_DATA;
      end
      if (data_valid && dv_prev && P_DATA !== pd_prev) n_unstable++;
      dv_prev = data_valid;
      pd_prev = P_DATA;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input bit b, input int ps);
      RX_IN = b;
      repeat (ps) @(negedge CLK);
   endtask

   task automatic run_frame(
      input string      tag,
      input logic [8:0] data,
      input int         len,
      input bit         pen,
      input bit         ptyp,
      input bit         st2,
      input int         ps,
      input bit         pflip,
      input bit         s1,
      input bit         s2
   );
      int         eff;
      logic [8:0] bits;
      bit         pbit, brk, perr, serr, good, ld, ovr;
      int         l0, p0, e0, o0, b0;
      eff  = (len < 5) ? 5 : (len > 9) ? 9 : len;
      bits = data & 9'((1 << eff) - 1);
      pbit = (^bits) ^ ptyp ^ pflip;
      brk  = (bits == 0) && !(pen && pbit) && !s1 && !(st2 && s2);
      perr = !brk && pen && pflip;
      serr = !brk && (!s1 || (st2 && !s2));
      good = !brk && !perr && !serr;
      ld   = good && (!hv || Data_Ready);
      ovr  = good && hv && !Data_Ready;
      if (ld) begin
         hv = 1'b1;
         hd = bits;
      end
      l0 = n_load; p0 = n_perr; e0 = n_serr; o0 = n_ovr; b0 = n_brk;
      PAR_EN   = pen;
      PAR_TYP  = ptyp;
      STOP2    = st2;
      Data_Len = 4'(len);
      Prescale = 6'(ps);
      send_bit(1'b0, ps);
      for (int i = 0; i < eff; i++) send_bit(bits[i], ps);
      if (pen) send_bit(pbit, ps);
      send_bit(s1, ps);
      if (st2) send_bit(s2, ps);
      RX_IN = 1'b1;
      repeat (2 * ps + 6) @(negedge CLK);
      if (Data_Ready) hv = 1'b0;
      check($sformatf("%s load", tag), n_load - l0, ld);
      check($sformatf("%s par", tag),  n_perr - p0, perr);
      check($sformatf("%s stop", tag), n_serr - e0, serr);
      check($sformatf("%s ovr", tag),  n_ovr - o0,  ovr);
      check($sformatf("%s brk", tag),  n_brk - b0,  brk);
      check($sformatf("%s pdata", tag), P_DATA, hd);
      check($sformatf("%s valid", tag), data_valid, hv);
      if (ld) check($sformatf("%s word", tag), last_load, bits);
   endtask

   initial begin
      int v0, l0, p0, e0, o0, b0;

      repeat (3) @(negedge CLK);
      check("rst pdata", P_DATA, 0);
      check("rst valid", data_valid, 0);
      check("rst par",   Parity_Error, 0);
      check("rst stop",  Stop_Error, 0);
      check("rst ovr",   Overrun_Error, 0);
      check("rst brk",   Break_Det, 0);
      RST = 1'b0;
      repeat (5) @(negedge CLK);

      v0 = n_vcyc;
      run_frame("8n1", 9'h099, 8, 0, 0, 0, 8, 0, 1, 1);
      check("8n1 vcyc", n_vcyc - v0, 1);

      run_frame("odd ok",  9'h155, 9, 1, 1, 0, 16, 0, 1, 1);
      run_frame("odd bad", 9'h155, 9, 1, 1, 0, 16, 1, 1, 1);

      run_frame("stop2 bad", 9'h055, 7, 0, 0, 1, 8, 0, 1, 0);

      Data_Ready = 1'b0;
      run_frame("ovr a", 9'h099, 8, 0, 0, 0, 8, 0, 1, 1);
      run_frame("ovr b", 9'h055, 8, 0, 0, 0, 8, 0, 1, 1);
      Data_Ready = 1'b1;
      @(negedge CLK);
      hv = 1'b0;
      check("ready clr", data_valid, 0);
      check("ready keep", P_DATA, 9'h099);

      l0 = n_load; p0 = n_perr; e0 = n_serr; o0 = n_ovr; b0 = n_brk;
      RX_IN = 1'b0;
      repeat (3) @(negedge CLK);
      RX_IN = 1'b1;
      repeat (40) @(negedge CLK);
      check("glitch pulses",
            (n_load - l0) + (n_perr - p0) + (n_serr - e0) +
            (n_ovr - o0) + (n_brk - b0), 0);

      PAR_EN = 1'b0; STOP2 = 1'b0; Data_Len = 4'd8; Prescale = 6'd8;
      RX_IN = 1'b0;
      repeat (12 * 8) @(negedge CLK);
      RX_IN = 1'b1;
      repeat (30) @(negedge CLK);
      check("break brk",  n_brk - b0, 1);
      check("break load", n_load - l0, 0);
      check("break par",  n_perr - p0, 0);
      check("break stop", n_serr - e0, 0);
      run_frame("post brk", 9'h0c3, 8, 0, 0, 0, 8, 0, 1, 1);

      Data_Ready = 1'b0;
      run_frame("pre rst", 9'h03c, 8, 1, 0, 0, 8, 0, 1, 1);
      send_bit(1'b0, 8);
      for (int i = 0; i < 4; i++) send_bit(i[0], 8);
      RX_IN = 1'b1;
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      hv = 1'b0;
      hd = '0;
      check("mid rst pdata", P_DATA, 0);
      check("mid rst valid", data_valid, 0);
      check("mid rst pulses",
            {Parity_Error, Stop_Error, Overrun_Error, Break_Det}, 0);
      repeat (20) @(negedge CLK);
      Data_Ready = 1'b1;
      run_frame("post rst", 9'h0a5, 8, 0, 0, 0, 8, 0, 1, 1);

      for (int k = 0; k < 24; k++) begin
         run_frame($sformatf("rnd%0d", k),
                   9'($urandom_range(0, 511)),
                   int'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)),
                   2 * int'($urandom_range(2, 10)),
                   $urandom_range(0, 3) == 0,
                   $urandom_range(0, 4) != 0,
                   $urandom_range(0, 4) != 0);
      end

      check("pdata stable", n_unstable, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
